// File: rtl/fifo_ctrl_pkg.sv
// Shared widths and level-update encoding for the FIFO controller.
// Width helpers are constant functions so they can size ports.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      LVL_HOLD = 2'd0,
      LVL_INC  = 2'd1,
      LVL_DEC  = 2'd2
   } lvl_upd_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth + 2);
   endfunction

   function automatic lvl_upd_t lvl_upd(input logic push, input logic pop);
      lvl_upd_t op;
      case ({push, pop})
         2'b10:   op = LVL_INC;
         2'b01:   op = LVL_DEC;
         default: op = LVL_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Read data is zero when the read port is not enabled.
module dp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = rd_en ? mem[rd_addr] : '0;

endmodule

// File: rtl/fifo_ctrl_out_stage.sv
// Output register stage: holds the head entry and decides when to refill it from RAM.
// A refill replaces the head whenever it is empty or being consumed this cycle.
module fifo_ctrl_out_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  ram_avail,
   input  logic                  pop_ready,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  refill,
   output logic                  pop_done,
   output logic                  pop_valid,
   output logic [DATA_WIDTH-1:0] pop_data
);

   assign refill   = ram_avail && (!pop_valid || pop_ready);
   assign pop_done = pop_valid && pop_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pop_valid <= 1'b0;
         pop_data  <= '0;
      end else if (refill) begin
         pop_valid <= 1'b1;
         pop_data  <= ram_data_out;
      end else if (pop_done) begin
         pop_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM plus a registered output stage.
// Optional almost_full/almost_empty flags are enabled by FIFO_CTRL_ALMOST_EN.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RAM_DEPTH  = 8,
   parameter int BASE_ADDR  = 0,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 1,
   localparam int AW = $clog2(BASE_ADDR + RAM_DEPTH),
   localparam int LW = lvl_w(RAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  push_valid,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  push_ready,
   output logic                  pop_valid,
   output logic [DATA_WIDTH-1:0] pop_data,
   input  logic                  pop_ready,
   output logic                  ram_wr_en,
   output logic [AW-1:0]         ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_rd_en,
   output logic [AW-1:0]         ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic [LW-1:0]         level
`ifdef FIFO_CTRL_ALMOST_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int PW = ptr_w(RAM_DEPTH);
   localparam int CW = cnt_w(RAM_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
   localparam logic [AW-1:0] BASE_C  = AW'(BASE_ADDR);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] ram_count;
   logic          push_acc;
   logic          ram_avail;
   logic          refill;
   logic          pop_done;
   lvl_upd_t      lvl_op;
   logic [LW-1:0] level_nxt;

   // Readiness depends only on registered count, never on this cycle's refill.
   assign push_ready = n_rst && (ram_count < DEPTH_C);
   assign push_acc   = push_valid && push_ready;
   assign ram_avail  = n_rst && (ram_count != '0);

   assign ram_wr_en   = push_acc;
   assign ram_wr_addr = BASE_C + AW'(wr_ptr);
   assign ram_data_in = push_data;
   assign ram_rd_en   = refill;
   assign ram_rd_addr = BASE_C + AW'(rd_ptr);

   fifo_ctrl_out_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_stage (
      .clk          (clk),
      .n_rst        (n_rst),
      .ram_avail    (ram_avail),
      .pop_ready    (pop_ready),
      .ram_data_out (ram_data_out),
      .refill       (refill),
      .pop_done     (pop_done),
      .pop_valid    (pop_valid),
      .pop_data     (pop_data)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (refill)   rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, refill})
            2'b10:   ram_count <= ram_count + 1'b1;
            2'b01:   ram_count <= ram_count - 1'b1;
            default: ram_count <= ram_count;
         endcase
      end
   end

   // Level counts the output register too, so it tracks completed pops, not refills.
   assign lvl_op = lvl_upd(push_acc, pop_done);

   always_comb begin
      level_nxt = level;
      case (lvl_op)
         LVL_INC: level_nxt = level + 1'b1;
         LVL_DEC: level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) level <= '0;
      else        level <= level_nxt;
   end

`ifdef FIFO_CTRL_ALMOST_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (int'(level_nxt) >= AF_THRESH);
         almost_empty <= (int'(level_nxt) <= AE_THRESH);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with an attached dp_ram and a data/address scoreboard.
module tb_fifo_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int BASE  = 16;
   localparam int AW    = $clog2(BASE + DEPTH);
   localparam int LW    = $clog2(DEPTH + 2);

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          push_valid = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          push_ready;
   logic          pop_valid;
   logic [DW-1:0] pop_data;
   logic          pop_ready = 1'b0;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_data_in;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_data_out;
   logic [LW-1:0] level;
`ifdef FIFO_CTRL_ALMOST_EN
   logic          almost_full;
   logic          almost_empty;
`endif

   int errors = 0;
   int checks = 0;
   int mdl_level = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int pop_cnt = 0;
   logic [DW-1:0] sb [$];

   always #5 clk = ~clk;

   fifo_ctrl #(
      .DATA_WIDTH (DW),
      .RAM_DEPTH  (DEPTH),
      .BASE_ADDR  (BASE),
      .AF_THRESH  (6),
      .AE_THRESH  (1)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .push_valid   (push_valid),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .pop_valid    (pop_valid),
      .pop_data     (pop_data),
      .pop_ready    (pop_ready),
      .ram_wr_en    (ram_wr_en),
      .ram_wr_addr  (ram_wr_addr),
      .ram_data_in  (ram_data_in),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_addr  (ram_rd_addr),
      .ram_data_out (ram_data_out),
      .level        (level)
`ifdef FIFO_CTRL_ALMOST_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   dp_ram #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_data_in),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_data_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs already driven; sample at negedge, return 1 unit after posedge.
   task automatic cycle();
      logic push_acc;
      logic pop_acc;
      @(negedge clk);
      push_acc = push_valid && push_ready;
      pop_acc  = pop_valid && pop_ready;
      chk("level", 32'(level), 32'(mdl_level));
      chk("wr_en", 32'(ram_wr_en), 32'(push_acc));
`ifdef FIFO_CTRL_ALMOST_EN
      chk("almost_full", 32'(almost_full), 32'(mdl_level >= 6));
      chk("almost_empty", 32'(almost_empty), 32'(mdl_level <= 1));
`endif
      if (push_acc) begin
         chk("wr_addr", 32'(ram_wr_addr), 32'(BASE + (wr_cnt % DEPTH)));
         chk("wr_data", 32'(ram_data_in), 32'(push_data));
         sb.push_back(push_data);
         wr_cnt++;
      end
      if (ram_rd_en) begin
         chk("rd_addr", 32'(ram_rd_addr), 32'(BASE + (rd_cnt % DEPTH)));
         rd_cnt++;
      end
      if (pop_acc) begin
         if (sb.size() == 0) chk("pop_unexpected", 32'(pop_valid), 32'd0);
         else                chk("pop_data", 32'(pop_data), 32'(sb.pop_front()));
         pop_cnt++;
      end
      mdl_level = mdl_level + int'(push_acc) - int'(pop_acc);
      @(posedge clk);
      #1;
   endtask

   // Called 1 unit after a rising edge; asserts reset mid-cycle and releases before the next edge.
   task automatic do_reset();
      #2;
      n_rst      = 1'b0;
      push_valid = 1'b1;
      pop_ready  = 1'b1;
      #1;
      chk("rst_push_ready", 32'(push_ready), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("rst_pop_data", 32'(pop_data), 32'd0);
`ifdef FIFO_CTRL_ALMOST_EN
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
      sb.delete();
      mdl_level = 0;
      wr_cnt    = 0;
      rd_cnt    = 0;
      pop_cnt   = 0;
      @(posedge clk);
      #1;
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      #2;
      n_rst = 1'b1;
   endtask

   task automatic drain();
      push_valid = 1'b0;
      pop_ready  = 1'b1;
      for (int k = 0; k < 40 && (mdl_level != 0 || pop_valid); k++) cycle();
      chk("drained_level", 32'(level), 32'd0);
      chk("drained_sb", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Single entry: no write-to-read bypass, two edges to appear.
      push_valid = 1'b1;
      push_data  = 8'h11;
      pop_ready  = 1'b1;
      cycle();
      push_valid = 1'b0;
      chk("one_pv_edge1", 32'(pop_valid), 32'd0);
      chk("one_level_edge1", 32'(level), 32'd1);
      cycle();
      chk("one_pv_edge2", 32'(pop_valid), 32'd1);
      chk("one_pd_edge2", 32'(pop_data), 32'h11);
      cycle();
      chk("one_pv_edge3", 32'(pop_valid), 32'd0);
      chk("one_level_edge3", 32'(level), 32'd0);

      // Fill: RAM plus output register holds DEPTH+1 entries.
      pop_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_valid = 1'b1;
         push_data  = DW'(i);
         chk("fill_push_ready", 32'(push_ready), 32'd1);
         cycle();
      end
      chk("full_push_ready", 32'(push_ready), 32'd0);
      chk("full_level", 32'(level), 32'(DEPTH + 1));
      chk("full_head_hold", 32'(pop_data), 32'd0);

      // Full with simultaneous push and pop: push refused, then accepted next cycle.
      push_data = 8'h99;
      pop_ready = 1'b1;
      cycle();
      chk("full_pop_level", 32'(level), 32'(DEPTH));
      chk("after_pop_push_ready", 32'(push_ready), 32'd1);
      cycle();
      chk("refill_push_level", 32'(level), 32'(DEPTH));
      drain();
      chk("fill_pop_count", 32'(pop_cnt), 32'(DEPTH + 3));

      // Streaming with address wrap at a non-zero base.
      do_reset();
      push_valid = 1'b1;
      pop_ready  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_data = DW'(8'h40 + i);
         cycle();
      end
      drain();
      chk("stream_wr_count", 32'(wr_cnt), 32'd20);
      chk("stream_pop_count", 32'(pop_cnt), 32'd20);

      // Reset mid-stream, then recover.
      pop_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_valid = 1'b1;
         push_data  = DW'(8'h60 + i);
         cycle();
      end
      chk("pre_reset_level", 32'(level), 32'd5);
      do_reset();
      push_valid = 1'b1;
      push_data  = 8'hAA;
      pop_ready  = 1'b1;
      cycle();
      chk("post_reset_level", 32'(level), 32'd1);
      drain();
      chk("post_reset_pops", 32'(pop_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, entry width in bits.
REQ-002 Parameter RAM_DEPTH, default 8, RAM entries; power of two, >= 2.
REQ-003 Parameter BASE_ADDR, default 0, first RAM address used.
REQ-004 Parameter AF_THRESH, default 6, almost_full asserts when level >= AF_THRESH.
REQ-005 Parameter AE_THRESH, default 1, almost_empty asserts when level <= AE_THRESH.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 n_rst  input  1  reset, asynchronous, active-low.
REQ-008 push_valid  input  1  producer offers push_data.
REQ-009 push_data  input  DATA_WIDTH  entry to store.
REQ-010 push_ready  output  1  controller accepts push this cycle.
REQ-011 pop_valid  output  1  pop_data holds valid head entry.
REQ-012 pop_data  output  DATA_WIDTH  head entry, registered.
REQ-013 pop_ready  input  1  consumer takes head this cycle.
REQ-014 ram_wr_en / ram_wr_addr / ram_data_in  output  1 / AW / DATA_WIDTH  RAM write port; AW = $clog2(BASE_ADDR+RAM_DEPTH).
REQ-015 ram_rd_en / ram_rd_addr  output  1 / AW  RAM asynchronous read port.
REQ-016 ram_data_out  input  DATA_WIDTH  RAM read data, valid in same cycle as ram_rd_addr.
REQ-017 level  output  $clog2(RAM_DEPTH+2)  entries held, RAM plus output register, 0..RAM_DEPTH+1.

Function
REQ-018 Push accepted when push_valid && push_ready; push_ready = (ram_count < RAM_DEPTH), from registered state only.
REQ-019 Accepted push drives ram_wr_en=1, ram_wr_addr=BASE_ADDR+wr_ptr, ram_data_in=push_data in same cycle; wr_ptr increments at edge.
REQ-020 Pointers wrap RAM_DEPTH-1 -> 0, so addresses wrap BASE_ADDR+RAM_DEPTH-1 -> BASE_ADDR.
REQ-021 Refill when ram_count > 0 and (!pop_valid or pop_ready): ram_rd_en=1, ram_rd_addr=BASE_ADDR+rd_ptr; pop_data <= ram_data_out, pop_valid <= 1, rd_ptr increments.
REQ-022 Pop with pop_valid && pop_ready and no refill: pop_valid <= 0.
REQ-023 ram_rd_en and ram_wr_en are 0 whenever no refill / no accepted push.
REQ-024 No write-to-read bypass: push accepted at edge k gives pop_valid=1 after edge k+1 at earliest.
REQ-025 Push and refill in same cycle: ram_count unchanged; push into full RAM is refused even if refill frees a slot that cycle.
REQ-026 Refill in a cycle where RAM is empty before the edge does not occur, even if push accepted that cycle.
REQ-027 pop_data holds its value while pop_valid && !pop_ready.
REQ-028 level updates at edge: +1 per accepted push, -1 per completed pop; simultaneous push and pop leaves it unchanged.

Reset
REQ-029 Assertion of n_rst, any cycle, immediately clears wr_ptr, rd_ptr, ram_count, level, pop_valid, pop_data.
REQ-030 During reset push_ready=0, ram_wr_en=0, ram_rd_en=0; RAM contents untouched but unreachable.
REQ-031 First push accepted in first cycle after n_rst deasserts.

Configuration
REQ-032 Macro FIFO_CTRL_ALMOST_EN defined: outputs almost_full and almost_empty (1 bit each, registered, from level per REQ-004/005); reset values 0 and 1.
REQ-033 FIFO_CTRL_ALMOST_EN undefined: ports and logic absent; all other behaviour identical.

Structure
REQ-034 Package fifo_ctrl_pkg holds pointer/count width functions and the level-update encoding type.
REQ-035 Output register stage (pop_valid/pop_data, refill decision) is sub-module fifo_ctrl_out_stage.
REQ-036 Top connects to dp_ram write/read ports with matching DATA_WIDTH, RAM_DEPTH, BASE_ADDR.

Verification
REQ-037 Reset, push 0x11 once, pop_ready=1 -> pop_valid after 2nd edge, pop_data=0x11, level 1 then 0.
REQ-038 Push 0x00..0x08 with pop_ready=0, RAM_DEPTH=8 -> 9 accepted, push_ready=0 after 9th, level=9.
REQ-039 BASE_ADDR=16, push/pop 20 entries -> ram_wr_addr sequence 16..23,16..; data out in order.
REQ-040 Full RAM, push_valid=1 and pop_ready=1 same cycle -> push refused, level 9->8, next cycle push accepted.
REQ-041 n_rst pulsed low mid-stream at level 5 -> level=0, pop_valid=0 instantly; next push 0xAA popped as 0xAA.
REQ-042 FIFO_CTRL_ALMOST_EN defined, fill to 6 -> almost_full=1 after 6th edge; drain to 1 -> almost_empty=1.
